// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if -- handshake and data bundle for the iterative shifter.
//   master : request side; drives Start, InstructionReg, Rm, CarryIn and
//            observes O, CarryOut, Busy, Done.
//   slave  : the shifter itself; the mirror image of master.
// Signal names are kept identical to the original flat port list so that
// existing callers map one-to-one onto the bundle.
interface shift_sequencer_if;
  logic        Start;
  logic [31:0] InstructionReg;
  logic [31:0] Rm;
  logic        CarryIn;
  logic [31:0] O;
  logic        CarryOut;
  logic        Busy;
  logic        Done;

  modport master (
    output Start, InstructionReg, Rm, CarryIn,
    input  O, CarryOut, Busy, Done
  );

  modport slave (
    input  Start, InstructionReg, Rm, CarryIn,
    output O, CarryOut, Busy, Done
  );
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer -- one-bit-per-cycle shifter-operand generator.
//   Clk   : sole clock, rising edge.
//   Reset : synchronous, active-low; clears state and all outputs.
//   bus   : shift_sequencer_if.slave
//     Start/InstructionReg/Rm/CarryIn : request, sampled only when accepted
//                                       in IDLE.
//     O/CarryOut : registered result, held in IDLE until the next request.
//     Busy       : high from the accepting edge through the Done cycle.
//     Done       : one-cycle pulse marking O/CarryOut valid.
// The operand, step count, operation and fill bit are decoded from the
// instruction on the accepting edge; SHIFT then moves O one bit per cycle
// until the counter reaches zero, and DONE raises the completion pulse.
module shift_sequencer (
  input logic            Clk,
  input logic            Reset,
  shift_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_LSL,
    OP_LSR,
    OP_ASR,
    OP_ROR,
    OP_RRX
  } op_t;

  state_t      state;
  op_t         op;
  logic [5:0]  count;
  logic        fill;

  // decoded request, valid while Start is presented in IDLE
  logic [31:0] dec_opnd;
  logic [5:0]  dec_count;
  op_t         dec_op;
  logic        dec_fill;

  // one step of the current operation applied to O
  logic [31:0] step_o;
  logic        step_c;

  logic [31:0] ir;
  logic [4:0]  imm;
  logic [2:0]  cls;

  assign ir  = bus.InstructionReg;
  assign imm = ir[11:7];
  assign cls = ir[27:25];

  // condition field and bit 24 play no part in operand generation
  logic unused_ir;
  assign unused_ir = &{1'b0, ir[31:28], ir[24]};

  always_comb begin
    dec_opnd  = {20'b0, ir[11:0]};
    dec_count = '0;
    dec_op    = OP_LSL;
    dec_fill  = 1'b0;
    if (cls == 3'b001) begin
      // rotated 8-bit immediate, rotate amount is twice the 4-bit field
      dec_opnd  = {24'b0, ir[7:0]};
      dec_count = {1'b0, ir[11:8], 1'b0};
      dec_op    = OP_ROR;
    end else if (cls == 3'b000 && !ir[4]) begin
      dec_opnd = bus.Rm;
      unique case (ir[6:5])
        2'b00: begin
          dec_op    = OP_LSL;
          dec_count = {1'b0, imm};
        end
        2'b01: begin
          dec_op    = OP_LSR;
          dec_count = (imm == 5'd0) ? 6'd32 : {1'b0, imm};
        end
        2'b10: begin
          dec_op    = OP_ASR;
          dec_count = (imm == 5'd0) ? 6'd32 : {1'b0, imm};
          dec_fill  = bus.Rm[31];
        end
        default: begin
          if (imm == 5'd0) begin
            // ROR #0 encodes RRX: single step, carry flag enters bit 31
            dec_op    = OP_RRX;
            dec_count = 6'd1;
            dec_fill  = bus.CarryIn;
          end else begin
            dec_op    = OP_ROR;
            dec_count = {1'b0, imm};
          end
        end
      endcase
    end else if (cls == 3'b101) begin
      // branch offset: sign-extended word offset scaled by 4
      dec_opnd  = {{8{ir[23]}}, ir[23:0]};
      dec_count = 6'd2;
      dec_op    = OP_LSL;
    end
  end

  always_comb begin
    step_o = bus.O;
    step_c = bus.CarryOut;
    case (op)
      OP_LSL: begin
        step_o = {bus.O[30:0], 1'b0};
        step_c = bus.O[31];
      end
      OP_LSR: begin
        step_o = {1'b0, bus.O[31:1]};
        step_c = bus.O[0];
      end
      OP_ASR, OP_RRX: begin
        // fill was latched at acceptance: original bit 31 or CarryIn
        step_o = {fill, bus.O[31:1]};
        step_c = bus.O[0];
      end
      OP_ROR: begin
        step_o = {bus.O[0], bus.O[31:1]};
        step_c = bus.O[0];
      end
      default: begin
        step_o = bus.O;
        step_c = bus.CarryOut;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state        <= IDLE;
      op           <= OP_LSL;
      count        <= '0;
      fill         <= 1'b0;
      bus.O        <= '0;
      bus.CarryOut <= 1'b0;
      bus.Busy     <= 1'b0;
      bus.Done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            // CarryOut preloads CarryIn so a zero-step op reports it unchanged
            bus.O        <= dec_opnd;
            bus.CarryOut <= bus.CarryIn;
            count        <= dec_count;
            op           <= dec_op;
            fill         <= dec_fill;
            bus.Busy     <= 1'b1;
            state        <= SHIFT;
          end
        end
        SHIFT: begin
          if (count != 6'd0) begin
            bus.O        <= step_o;
            bus.CarryOut <= step_c;
            count        <= count - 6'd1;
          end else begin
            bus.Done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          bus.Done <= 1'b0;
          bus.Busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.Done <= 1'b0;
          bus.Busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer -- self-checking bench for shift_sequencer.
// A transaction-level model predicts Busy/Done timing from the latency rule
// (Done after edge k+n+1) and the final O/CarryOut from whole-word shift
// arithmetic; a compare process checks the DUT against it every cycle.
module tb_shift_sequencer;

  logic Clk;
  logic Reset;

  shift_sequencer_if sif ();

  shift_sequencer dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (sif)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-word reference: decode, then apply the full shift in one step.
  task automatic model_compute(input logic [31:0] ir, input logic [31:0] rm, input logic cin,
                               output logic [31:0] o, output logic c, output int n);
    logic [31:0] opnd;
    logic [63:0] w;
    int kind; // 0 LSL, 1 LSR, 2 ASR, 3 ROR, 4 RRX
    int imm;
    imm = int'(ir[11:7]);
    if (ir[27:25] == 3'b001) begin
      opnd = {24'b0, ir[7:0]}; n = 2 * int'(ir[11:8]); kind = 3;
    end else if (ir[27:25] == 3'b000 && ir[4] == 1'b0) begin
      opnd = rm;
      case (ir[6:5])
        2'b00: begin kind = 0; n = imm; end
        2'b01: begin kind = 1; n = (imm == 0) ? 32 : imm; end
        2'b10: begin kind = 2; n = (imm == 0) ? 32 : imm; end
        default: begin
          if (imm == 0) begin kind = 4; n = 1; end
          else begin kind = 3; n = imm; end
        end
      endcase
    end else if (ir[27:25] == 3'b101) begin
      opnd = {{8{ir[23]}}, ir[23:0]}; n = 2; kind = 0;
    end else begin
      opnd = {20'b0, ir[11:0]}; n = 0; kind = 0;
    end
    o = opnd; c = cin;
    if (n > 0) begin
      case (kind)
        0: begin w = {32'b0, opnd} << n; o = w[31:0]; c = w[32]; end
        1: begin w = {opnd, 32'b0} >> n; o = w[63:32]; c = w[31]; end
        2: begin w = 64'($signed({opnd, 32'b0}) >>> n); o = w[63:32]; c = w[31]; end
        3: begin w = {opnd, opnd} >> n; o = w[31:0]; c = o[31]; end
        default: begin o = {cin, opnd[31:1]}; c = opnd[0]; end
      endcase
    end
  endtask

  // Transaction-level model state
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  int          m_rem  = 0;
  logic [31:0] m_o    = '0;
  logic        m_c    = 1'b0;
  logic [31:0] m_res_o = '0;
  logic        m_res_c = 1'b0;

  always @(posedge Clk) begin
    logic [31:0] ro;
    logic        rc;
    int          rn;
    if (!Reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_rem = 0; m_o = '0; m_c = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0; m_busy = 1'b0;
    end else if (m_busy) begin
      if (m_rem == 1) begin
        m_done = 1'b1; m_o = m_res_o; m_c = m_res_c; m_rem = 0;
      end else begin
        m_rem = m_rem - 1;
      end
    end else if (sif.Start) begin
      model_compute(sif.InstructionReg, sif.Rm, sif.CarryIn, ro, rc, rn);
      m_res_o = ro; m_res_c = rc; m_rem = rn + 1; m_busy = 1'b1;
    end
  end

  // Every-cycle comparison; O/CarryOut are only meaningful when Done or idle.
  always @(negedge Clk) begin
    if (check_en) begin
      check("busy", 32'(sif.Busy), 32'(m_busy));
      check("done", 32'(sif.Done), 32'(m_done));
      if (m_done || !m_busy) begin
        check("o", sif.O, m_o);
        check("carry", 32'(sif.CarryOut), 32'(m_c));
      end
    end
  end

  function automatic logic [31:0] gen_ir();
    logic [31:0] ir;
    ir = $urandom;
    case ($urandom_range(0, 3))
      0: ir[27:25] = 3'b001;
      1: begin
        ir[27:25] = 3'b000; ir[4] = 1'b0;
        if ($urandom_range(0, 3) == 0) ir[11:7] = 5'd0;
      end
      2: ir[27:25] = 3'b101;
      default: ;
    endcase
    return ir;
  endfunction

  task automatic drive_req(input logic [31:0] ir, input logic [31:0] rm, input logic cin);
    sif.Start = 1'b1; sif.InstructionReg = ir; sif.Rm = rm; sif.CarryIn = cin;
  endtask

  task automatic scramble();
    sif.InstructionReg = $urandom; sif.Rm = $urandom; sif.CarryIn = 1'($urandom);
  endtask

  // Directed transaction with literal expectations; caller is at a negedge.
  task automatic run_directed(input string name, input logic [31:0] ir, input logic [31:0] rm,
                              input logic cin, input logic [31:0] exp_o, input logic exp_c,
                              input int exp_edges, input bit second_start);
    int edges;
    drive_req(ir, rm, cin);
    @(posedge Clk);
    edges = 1;
    @(negedge Clk);
    sif.Start = 1'b0;
    scramble();
    while (!sif.Done && edges < 60) begin
      @(posedge Clk);
      edges++;
      @(negedge Clk);
      if (second_start && edges == 3) drive_req(gen_ir(), $urandom, 1'($urandom));
      else sif.Start = 1'b0;
    end
    sif.Start = 1'b0;
    check({name, "_edges"}, 32'(edges), 32'(exp_edges));
    check({name, "_o"}, sif.O, exp_o);
    check({name, "_carry"}, 32'(sif.CarryOut), 32'(exp_c));
    // Start presented during the Done cycle must be dropped
    drive_req(gen_ir(), $urandom, 1'($urandom));
    @(posedge Clk);
    @(negedge Clk);
    sif.Start = 1'b0;
    check({name, "_start_in_done"}, 32'(sif.Busy), 32'd0);
    check({name, "_hold_o"}, sif.O, exp_o);
  endtask

  initial begin
    logic [31:0] po;
    logic        pc;
    int          pn;
    int          dones;

    Reset = 1'b0;
    sif.Start = 1'b0; sif.InstructionReg = '0; sif.Rm = '0; sif.CarryIn = 1'b0;

    // Model pinned against hand-worked results
    model_compute(32'hE3A004FF, 32'h0, 1'b0, po, pc, pn);
    check("pin_rotimm_o", po, 32'hFF000000);
    check("pin_rotimm_n", 32'(pn), 32'd8);
    model_compute(32'hE1A00021, 32'h80000000, 1'b0, po, pc, pn);
    check("pin_lsr32_o", po, 32'h0);
    check("pin_lsr32_c", 32'(pc), 32'd1);
    model_compute(32'hE1A00240, 32'h80000000, 1'b1, po, pc, pn);
    check("pin_asr4_o", po, 32'hF8000000);
    check("pin_asr4_c", 32'(pc), 32'd0);
    model_compute(32'hE1A00060, 32'h00000001, 1'b1, po, pc, pn);
    check("pin_rrx_o", po, 32'h80000000);
    check("pin_rrx_n", 32'(pn), 32'd1);
    model_compute(32'hEAFFFFFE, 32'h0, 1'b0, po, pc, pn);
    check("pin_branch_o", po, 32'hFFFFFFF8);

    @(posedge Clk);
    @(negedge Clk);
    check_en = 1'b1;
    check("reset_o", sif.O, 32'h0);
    check("reset_busy", 32'(sif.Busy), 32'd0);
    check("reset_done", 32'(sif.Done), 32'd0);
    Reset = 1'b1;
    @(negedge Clk);

    run_directed("rotimm", 32'hE3A004FF, 32'h12345678, 1'b0, 32'hFF000000, 1'b1, 10, 1'b0);
    run_directed("lsr32", 32'hE1A00021, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 34, 1'b0);
    run_directed("asr4", 32'hE1A00240, 32'h80000000, 1'b1, 32'hF8000000, 1'b0, 6, 1'b1);
    run_directed("rrx", 32'hE1A00060, 32'h00000001, 1'b1, 32'h80000000, 1'b1, 3, 1'b0);
    run_directed("branch", 32'hEAFFFFFE, 32'h0, 1'b0, 32'hFFFFFFF8, 1'b1, 4, 1'b0);
    run_directed("other_c1", 32'hE5900ABC, 32'h0, 1'b1, 32'h00000ABC, 1'b1, 2, 1'b0);
    run_directed("other_c0", 32'hE5900ABC, 32'h0, 1'b0, 32'h00000ABC, 1'b0, 2, 1'b0);

    // Abort LSR #32 with reset on the 5th edge; Start held alongside reset
    drive_req(32'hE1A00021, 32'h80000000, 1'b0);
    @(posedge Clk);
    @(negedge Clk);
    sif.Start = 1'b0;
    repeat (3) begin
      @(posedge Clk);
      @(negedge Clk);
    end
    Reset = 1'b0;
    drive_req(32'hE3A004FF, 32'h0, 1'b1);
    @(posedge Clk);
    @(negedge Clk);
    check("abort_o", sif.O, 32'h0);
    check("abort_busy", 32'(sif.Busy), 32'd0);
    check("abort_done", 32'(sif.Done), 32'd0);
    check("abort_carry", 32'(sif.CarryOut), 32'd0);
    Reset = 1'b1;
    sif.Start = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge Clk);
      if (sif.Done) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);

    // Randomized traffic: sporadic Start, occasional reset
    repeat (3000) begin
      @(negedge Clk);
      Reset = ($urandom_range(0, 99) != 0);
      sif.Start = ($urandom_range(0, 2) == 0);
      sif.InstructionReg = gen_ir();
      sif.Rm = $urandom;
      sif.CarryIn = 1'($urandom);
    end
    @(negedge Clk);
    Reset = 1'b1;
    sif.Start = 1'b0;
    repeat (40) @(negedge Clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
